// File: rtl/bram_bus_pkg.sv
// rtl/bram_bus_pkg.sv - size encodings, FSM states and lane helpers for the bram request adapter
// Contents: SZ_BYTE/SZ_HALF/SZ_WORD, state_t, lane_mask(size, offset), misaligned(size, offset)
package bram_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    // Active-high mask of byte lanes touched by an aligned access.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << offset;
            SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bram_load_align.sv
// rtl/bram_load_align.sv - extracts the addressed lanes of a RAM word and sign/zero-extends them
// Ports: mem_data_i (raw RAM word), offset_i (byte offset), size_i (access size),
//        unsigned_i (1 = zero-extend), result_o (right-justified load value)
module bram_load_align
    import bram_bus_pkg::*;
(
    input  logic [31:0] mem_data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;
    logic        sign_fill;

    always_comb begin
        shifted   = mem_data_i >> {offset_i, 3'b000};
        sign_fill = 1'b0;
        result_o  = shifted;
        case (size_i)
            SZ_BYTE: begin
                sign_fill = ~unsigned_i & shifted[7];
                result_o  = {{24{sign_fill}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign_fill = ~unsigned_i & shifted[15];
                result_o  = {{16{sign_fill}}, shifted[15:0]};
            end
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/bram_bus_if.sv
// rtl/bram_bus_if.sv - single byte/half/word load/store adapter in front of the bram macro
// Ports: clk, reset_n (sync, active low); request req_i/we_i/size_i/unsigned_i/addr_i/wdata_i;
//        completion ready_o/err_o/rdata_o; RAM side mem_addr_o/mem_cs_n_o/mem_we_n_o/mem_data_o/mem_data_i
module bram_bus_if
    import bram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  ready_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic [3:0]            mem_cs_n_o,
    output logic [3:0]            mem_we_n_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
);

    state_t                state, state_nxt;
    logic                  we_q;
    logic                  uns_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           load_val;
    logic [3:0]            lanes_n;
    logic                  accept;
    logic                  bad;

    // A new request can be taken while idle or in the completion cycle,
    // which is what gives back-to-back issue without a bubble.
    assign accept = req_i && ((state == IDLE) || (state == DONE));
    assign bad    = misaligned(size_i, addr_i[1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = bad ? DONE : ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS:  state_nxt = we_q ? DONE : CAPTURE;
            CAPTURE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= we_i;
                uns_q   <= unsigned_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= bad;
                if (bad) begin
                    rdata_q <= '0;
                end
            end
            // RAM output is valid during CAPTURE; stores never reach this state.
            if (state == CAPTURE) begin
                rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        lanes_n    = ~lane_mask(size_q, addr_q[1:0]);
        mem_cs_n_o = 4'hF;
        mem_we_n_o = 4'hF;
        if (state == ACCESS) begin
            mem_cs_n_o = lanes_n;
            mem_we_n_o = we_q ? lanes_n : 4'hF;
        end
    end

    // Narrow store data is replicated so whichever lane is strobed sees it.
    always_comb begin
        case (size_q)
            SZ_BYTE: mem_data_o = {4{wdata_q[7:0]}};
            SZ_HALF: mem_data_o = {2{wdata_q[15:0]}};
            default: mem_data_o = wdata_q;
        endcase
    end

    bram_load_align u_load_align (
        .mem_data_i (mem_data_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (load_val)
    );

    assign ready_o    = (state == DONE);
    assign err_o      = ready_o & err_q;
    assign rdata_o    = rdata_q;
    assign mem_addr_o = addr_q[ADDR_WIDTH-1:2];

endmodule

// File: tb/tb_bram_bus_if.sv
// tb/tb_bram_bus_if.sv - self-checking bench for bram_bus_if with a byte-level memory reference
module tb_bram_bus_if;

    logic        clk;
    logic        reset_n;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_cs_n_o;
    logic [3:0]  mem_we_n_o;
    logic [31:0] mem_data_o;
    logic [31:0] ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    bram_bus_if #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_cs_n_o (mem_cs_n_o),
        .mem_we_n_o (mem_we_n_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro stand-in: per-lane active-low strobes, one-cycle registered read.
    logic [31:0] ram [0:1023];
    logic        ram_clear;
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            ram_q <= '0;
        end else if (mem_cs_n_o != 4'hF) begin
            ram_q <= ram[mem_addr_o];
            for (int k = 0; k < 4; k++) begin
                if (!mem_cs_n_o[k] && !mem_we_n_o[k]) ram[mem_addr_o][8*k +: 8] <= mem_data_o[8*k +: 8];
            end
        end
    end

    // Reference: flat byte memory plus the last completed load value.
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] last_rdata;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_req(input logic we, input logic [1:0] sz, input logic uns, input logic [11:0] addr,
                             input logic [31:0] wd, output logic e_err, output int e_lat,
                             output logic [31:0] e_rd, output logic [3:0] e_cs, output logic [3:0] e_we,
                             output logic [31:0] e_md, output int e_nstb);
        int     n;
        int     a;
        longint v;
        n      = 1 << sz;
        a      = int'(addr);
        e_cs   = 4'hF;
        e_we   = 4'hF;
        e_md   = '0;
        if (sz == 2'd3 || (a % n) != 0) begin
            e_err = 1'b1; e_lat = 1; e_rd = '0; e_nstb = 0;
            last_rdata = '0;
            return;
        end
        e_err  = 1'b0;
        e_nstb = 1;
        for (int i = 0; i < n; i++) e_cs[(a + i) % 4] = 1'b0;
        for (int k = 0; k < 4; k++) e_md[8*k +: 8] = 8'(wd >> (8 * (k % n)));
        if (we) begin
            e_we = e_cs;
            for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
            e_lat = 2;
            e_rd  = last_rdata;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
            e_rd       = 32'(v);
            last_rdata = e_rd;
            e_lat      = 3;
        end
    endtask

    // Issue one request from IDLE and check everything observed up to completion.
    task automatic exercise(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wd, input logic e_err, input int e_lat,
                            input logic chk_rd, input logic [31:0] e_rd, input logic [3:0] e_cs,
                            input logic [3:0] e_we, input logic chk_md, input logic [31:0] e_md, input int e_nstb);
        int          cyc;
        int          nstb;
        logic [3:0]  cs_s;
        logic [3:0]  we_s;
        logic [31:0] md_s;
        logic [9:0]  ma_s;
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
        @(posedge clk); #1;
        req_i = 1'b0; addr_i = 12'($urandom); wdata_i = $urandom; size_i = 2'($urandom); we_i = ~we;
        cyc = 1; nstb = 0; cs_s = 4'hF; we_s = 4'hF; md_s = '0; ma_s = '0;
        while (1) begin
            if (mem_cs_n_o != 4'hF || mem_we_n_o != 4'hF) begin
                nstb++; cs_s = mem_cs_n_o; we_s = mem_we_n_o; md_s = mem_data_o; ma_s = mem_addr_o;
            end
            if (ready_o || cyc >= 8) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(e_lat));
        chk({nm, " err"}, {31'b0, err_o}, {31'b0, e_err});
        if (chk_rd) chk({nm, " rdata"}, rdata_o, e_rd);
        chk({nm, " strobe_cycles"}, 32'(nstb), 32'(e_nstb));
        chk({nm, " cs_n"}, {28'b0, cs_s}, {28'b0, e_cs});
        chk({nm, " we_n"}, {28'b0, we_s}, {28'b0, e_we});
        if (chk_md) chk({nm, " mem_data"}, md_s, e_md);
        if (nstb > 0) chk({nm, " mem_addr"}, {22'b0, ma_s}, {22'b0, addr[11:2]});
        @(posedge clk); #1;
        chk({nm, " ready_pulse"}, {31'b0, ready_o}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        err;
        int          lat;
        logic        chk_rd;
        logic [31:0] rd;
        logic [3:0]  cs;
        logic [3:0]  wen;
        logic        chk_md;
        logic [31:0] md;
        int          nstb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rd;
        logic [3:0]  e_cs;
        logic [3:0]  e_we;
        logic [31:0] e_md;
        int          e_nstb;
        logic        rw;
        logic [1:0]  rsz;
        logic        runs;
        logic [11:0] raddr;
        logic [31:0] rwd;
        int          pick;
        int          idx;
        int          done_idx;
        logic        prev_accept;
        logic [15:0] acc_mask;
        logic [15:0] rdy_mask;
        logic        b_we   [4];
        logic [11:0] b_addr [4];
        logic [31:0] b_wd   [4];
        logic [31:0] b_exp  [4];
        int          nready;

        //              we   sz    uns   addr     wdata          err  lat chk_rd rdata          cs       we_n     chk_md mem_data       nstb
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0,        4'b0000, 4'b0000, 1'b1, 32'hDEADBEEF, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 3, 1'b1, 32'hDEADBEEF, 4'b0000, 4'b1111, 1'b0, 32'h0,        1};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'hAABBCC80, 1'b0, 2, 1'b0, 32'h0,        4'b0111, 4'b0111, 1'b1, 32'h80808080, 1};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        1'b0, 3, 1'b1, 32'hFFFFFF80, 4'b0111, 4'b1111, 1'b0, 32'h0,        1};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 12'h013, 32'h0,        1'b0, 3, 1'b1, 32'h00000080, 4'b0111, 4'b1111, 1'b0, 32'h0,        1};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 12'h022, 32'h55558001, 1'b0, 2, 1'b0, 32'h0,        4'b0011, 4'b0011, 1'b1, 32'h80018001, 1};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 12'h022, 32'h0,        1'b0, 3, 1'b1, 32'hFFFF8001, 4'b0011, 4'b1111, 1'b0, 32'h0,        1};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 12'h020, 32'h0,        1'b0, 3, 1'b1, 32'h80010000, 4'b0000, 4'b1111, 1'b0, 32'h0,        1};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 12'h001, 32'h0,        1'b1, 1, 1'b1, 32'h0,        4'b1111, 4'b1111, 1'b0, 32'h0,        0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 12'h002, 32'h12345678, 1'b1, 1, 1'b1, 32'h0,        4'b1111, 4'b1111, 1'b0, 32'h0,        0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 12'h000, 32'h0,        1'b1, 1, 1'b1, 32'h0,        4'b1111, 4'b1111, 1'b0, 32'h0,        0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 12'h000, 32'h0,        1'b0, 3, 1'b1, 32'h0,        4'b0000, 4'b1111, 1'b0, 32'h0,        1};

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        last_rdata = '0;

        // Reset with a live request on the inputs: reset must dominate.
        reset_n = 1'b0; ram_clear = 1'b1;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 12'hFFC; wdata_i = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'b0, ready_o}, 32'd0);
        chk("reset err", {31'b0, err_o}, 32'd0);
        chk("reset rdata", rdata_o, 32'd0);
        chk("reset cs_n", {28'b0, mem_cs_n_o}, 32'hF);
        chk("reset we_n", {28'b0, mem_we_n_o}, 32'hF);
        chk("reset mem_addr", {22'b0, mem_addr_o}, 32'd0);
        chk("reset mem_data", mem_data_o, 32'd0);
        req_i = 1'b0; reset_n = 1'b1; ram_clear = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            model_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                      e_err, e_lat, e_rd, e_cs, e_we, e_md, e_nstb);
            exercise($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                     vecs[i].err, vecs[i].lat, vecs[i].chk_rd, vecs[i].rd, vecs[i].cs, vecs[i].wen,
                     vecs[i].chk_md, vecs[i].md, vecs[i].nstb);
        end

        // Randomized traffic over a small window so loads see earlier stores.
        for (int i = 0; i < 250; i++) begin
            pick  = $urandom_range(0, 9);
            rsz   = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
            rw    = 1'($urandom);
            runs  = 1'($urandom);
            raddr = 12'($urandom_range(0, 63));
            rwd   = $urandom;
            model_req(rw, rsz, runs, raddr, rwd, e_err, e_lat, e_rd, e_cs, e_we, e_md, e_nstb);
            exercise($sformatf("rnd%0d", i), rw, rsz, runs, raddr, rwd, e_err, e_lat, 1'b1, e_rd,
                     e_cs, e_we, rw && !e_err, e_md, e_nstb);
        end

        // Back-to-back: req_i held high over store/load/store/load.
        b_we[0] = 1'b1; b_addr[0] = 12'h030; b_wd[0] = 32'h11223344; b_exp[0] = 32'h0;
        b_we[1] = 1'b0; b_addr[1] = 12'h030; b_wd[1] = 32'h0;        b_exp[1] = 32'h11223344;
        b_we[2] = 1'b1; b_addr[2] = 12'h034; b_wd[2] = 32'hCAFEF00D; b_exp[2] = 32'h0;
        b_we[3] = 1'b0; b_addr[3] = 12'h034; b_wd[3] = 32'h0;        b_exp[3] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            model_req(b_we[i], 2'd2, 1'b0, b_addr[i], b_wd[i], e_err, e_lat, e_rd, e_cs, e_we, e_md, e_nstb);
        end
        idx = 0; done_idx = 0; prev_accept = 1'b1; acc_mask = '0; rdy_mask = '0;
        req_i = 1'b1; we_i = b_we[0]; size_i = 2'd2; unsigned_i = 1'b0; addr_i = b_addr[0]; wdata_i = b_wd[0];
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            if (prev_accept) begin
                idx++;
                if (idx < 4) begin
                    we_i = b_we[idx]; addr_i = b_addr[idx]; wdata_i = b_wd[idx];
                end else begin
                    req_i = 1'b0;
                end
            end
            if (mem_cs_n_o != 4'hF) acc_mask[c] = 1'b1;
            if (ready_o) begin
                rdy_mask[c] = 1'b1;
                if (done_idx < 4 && !b_we[done_idx]) chk($sformatf("b2b load%0d rdata", done_idx), rdata_o, b_exp[done_idx]);
                done_idx++;
            end
            prev_accept = ready_o && req_i;
        end
        chk("b2b access cycles", {16'b0, acc_mask}, 32'h0000_014A);
        chk("b2b ready cycles", {16'b0, rdy_mask}, 32'h0000_04A4);
        chk("b2b completions", 32'(done_idx), 32'd4);

        // Reset for one cycle while a load sits in CAPTURE.
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 12'h010; wdata_i = 32'h0;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_rdata = '0;
        chk("midrst ready", {31'b0, ready_o}, 32'd0);
        chk("midrst err", {31'b0, err_o}, 32'd0);
        chk("midrst rdata", rdata_o, 32'd0);
        chk("midrst cs_n", {28'b0, mem_cs_n_o}, 32'hF);
        chk("midrst we_n", {28'b0, mem_we_n_o}, 32'hF);
        chk("midrst mem_addr", {22'b0, mem_addr_o}, 32'd0);
        chk("midrst mem_data", mem_data_o, 32'd0);
        nready = 0;
        for (int c = 0; c < 4; c++) begin
            if (ready_o) nready++;
            @(posedge clk); #1;
        end
        chk("midrst no ready", 32'(nready), 32'd0);
        model_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, e_err, e_lat, e_rd, e_cs, e_we, e_md, e_nstb);
        exercise("post_reset load", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, e_err, e_lat, 1'b1, e_rd,
                 e_cs, e_we, 1'b0, e_md, e_nstb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_bus_if.md
# bram_bus_if

Request-side adapter placed directly upstream of the on-chip boot/data RAM macro (`bram`: 32-bit word array, per-byte-lane active-low chip selects and write enables, one-cycle registered read). It accepts single byte/half/word load and store requests from the core's data port. It generates lane strobes and replicated write data, waits out the RAM read latency, then aligns and sign/zero-extends load data. It signals completion with a one-cycle `ready_o` pulse and flags misaligned accesses without touching memory.

## Interface
- `ADDR_WIDTH`, 12, byte-address width; must match the downstream RAM's `ADDR_WIDTH`.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_i`  in  1  request valid; sampled only when the block can accept (see Operation).
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0.
- `addr_i`  in  ADDR_WIDTH  byte address.
- `wdata_i`  in  32  store data, right-justified.
- `ready_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  misalignment flag, valid only while `ready_o`=1.
- `rdata_o`  out  32  load result, held until the next completion.
- `mem_addr_o`  out  ADDR_WIDTH-2  word address to RAM (`addr[ADDR_WIDTH-1:2]`).
- `mem_cs_n_o`  out  4  per-lane chip select, active low.
- `mem_we_n_o`  out  4  per-lane write enable, active low.
- `mem_data_o`  out  32  write data to RAM.
- `mem_data_i`  in  32  read data from RAM.

## Operation
- Lane k = bits [8k+7:8k] = byte offset k (little-endian).
- FSM states:
  - IDLE: accepts requests.
  - ACCESS: drives strobes.
  - CAPTURE: read only; RAM data valid.
  - DONE: `ready_o`=1.
- Acceptance: `req_i`=1 in IDLE or DONE. The block latches `we_i`, `size_i`, `unsigned_i`, `addr_i` and `wdata_i` at the accepting edge. The requester may drop `req_i` afterwards.
- Misaligned requests go to DONE with `err_o`=1, `rdata_o`=0, and no strobes. A request is misaligned when:
  - `size_i`=01 and addr[0]=1, or
  - `size_i`=10 and addr[1:0]≠0, or
  - `size_i`=11.
- Lane select:
  - byte: lane addr[1:0];
  - half: lanes {1,0} if addr[1]=0, else {3,2};
  - word: all lanes.
- Strobes are asserted only in ACCESS, and are derived combinationally from the latched request:
  - `mem_cs_n_o` is low on the selected lanes.
  - `mem_we_n_o` equals `mem_cs_n_o` for stores and is 1111 for loads.
  - Outside ACCESS both strobe buses are 1111.
- Write data replication:
  - byte: wdata[7:0] on all four lanes;
  - half: wdata[15:0] on both halves;
  - word: unchanged.
- Transitions:
  - ACCESS → DONE for stores.
  - ACCESS → CAPTURE for loads.
  - CAPTURE → DONE; the aligned/extended load value is registered into `rdata_o` on the CAPTURE→DONE edge.
  - DONE → ACCESS or DONE if a new request is accepted, else → IDLE.
- Stores leave `rdata_o` unchanged.

## Timing
- Reset values:
  - state IDLE;
  - `ready_o`=0, `err_o`=0, `rdata_o`=0;
  - `mem_cs_n_o`=`mem_we_n_o`=1111;
  - `mem_addr_o`=0, `mem_data_o`=0.
- Latency, counted from the accepting edge E0:
  - store: strobes in cycle E0–E1, RAM writes at E1, `ready_o` high in cycle E1–E2;
  - load: strobes in cycle E0–E1, RAM data valid in E1–E2, `rdata_o` and `ready_o` valid in E2–E3;
  - misaligned: `ready_o`/`err_o` in E0–E1.
- Back-to-back: a request accepted in DONE starts ACCESS in the next cycle. Sustained throughput is one store per 2 cycles and one load per 3 cycles.
- `ready_o` is never high for two consecutive cycles unless back-to-back misaligned requests occur.
- Reset mid-operation:
  - A `reset_n` low sampled at an edge that ends an ACCESS cycle still commits that RAM write, because strobes were already presented.
  - All later strobes are suppressed, and no `ready_o` is issued for the aborted request.

## Structure
- Package `bram_bus_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `{IDLE, ACCESS, CAPTURE, DONE}`;
  - lane-mask function.
- One sub-module, `bram_load_align`: combinational lane extraction plus sign/zero extension from (`mem_data_i`, offset, size, unsigned).

## Test plan
- Store word 0xDEADBEEF @0x010, then load word @0x010:
  - store: cs_n=0000, we_n=0000, `ready_o` 2 cycles after acceptance;
  - load: `rdata_o`=0xDEADBEEF, `ready_o` 3 cycles after acceptance.
- Store byte 0x80 @0x013:
  - cs_n=we_n=0111, `mem_data_o`=0x80808080;
  - signed byte load @0x013 → 0xFFFFFF80;
  - unsigned byte load @0x013 → 0x00000080.
- Store half 0x8001 @0x022, then loads @0x022:
  - lanes {3,2}, `mem_data_o`=0x80018001;
  - signed half load → 0xFFFF8001;
  - load word @0x020 → upper half 0x8001, lower half unchanged.
- Misaligned requests (half @0x001, word @0x002, size 11): each gives `ready_o`=`err_o`=1 in the cycle after acceptance, strobes stay 1111, `rdata_o`=0.
- Back-to-back: hold `req_i`=1 across 4 alternating store/load requests → no idle cycles between ACCESS states, and every load returns the preceding store value.
- Reset asserted for one cycle during CAPTURE of a load → no `ready_o`, all outputs at reset values, next load completes normally.
